cacheline_adapter: RTL and testbench

- Responder for the L2 cache's physical-memory line interface (256-bit line read/write with pmem_resp handshake).
- Converts each line request into a 4-beat, 64-bit burst on the DRAM-side interface, then returns a single-cycle line response.
- Sits between l2_cache and main memory.
- It is the only path from the cache hierarchy to memory.

---
 rtl/mem_if_pkg.sv | 17 +
 rtl/cacheline_adapter.sv | 99 +++++++++
 tb/tb_cacheline_adapter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared memory-interface constants and the line adapter state encoding.
// Line geometry is fixed here so L2 and the adapter agree on it.
package mem_if_pkg;

  localparam int OFFSET_W  = 5;
  localparam int LINE_W    = 8 * (2 ** OFFSET_W);
  localparam int BEAT_W    = 64;
  localparam int NUM_BEATS = LINE_W / BEAT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Turns one L2 line request into a 4-beat DRAM burst and answers
// with a single-cycle pmem_resp once the last beat has moved.
module cacheline_adapter
  import mem_if_pkg::*;
#(
  parameter int s_offset = OFFSET_W,
  parameter int s_beat   = BEAT_W,
  localparam int line_w    = 8 * (2 ** s_offset),
  localparam int num_beats = line_w / s_beat,
  localparam int cnt_w     = $clog2(num_beats)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pmem_address,
  input  logic [line_w-1:0] pmem_wdata,
  output logic [line_w-1:0] pmem_rdata,
  input  logic              pmem_read,
  input  logic              pmem_write,
  output logic              pmem_resp,
  output logic [31:0]       burst_address,
  input  logic [s_beat-1:0] burst_rdata,
  output logic [s_beat-1:0] burst_wdata,
  output logic              burst_read,
  output logic              burst_write,
  input  logic              burst_resp
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_READ  = READ;
  localparam logic [1:0] S_WRITE = WRITE;
  localparam logic [1:0] S_DONE  = DONE;

  localparam logic [cnt_w-1:0] LAST = cnt_w'(num_beats - 1);

  logic [1:0]        state;
  logic [cnt_w-1:0]  cnt;
  logic [line_w-1:0] line_buf;
  logic [line_w-1:0] rdata_q;
  logic [31:0]       addr_q;
  logic              last_beat;

  assign last_beat = burst_resp && (cnt == LAST);

  // FSM, beat counter, write buffer and read-line assembly.
  // Read beats land straight in the output line so a later write
  // cannot disturb the last line returned to L2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      line_buf <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pmem_read) begin
            state  <= S_READ;
            cnt    <= '0;
            addr_q <= {pmem_address[31:s_offset], {s_offset{1'b0}}};
          end else if (pmem_write) begin
            state    <= S_WRITE;
            cnt      <= '0;
            line_buf <= pmem_wdata;
            addr_q   <= {pmem_address[31:s_offset], {s_offset{1'b0}}};
          end
        end
        S_READ: begin
          if (burst_resp) begin
            rdata_q[cnt*s_beat +: s_beat] <= burst_rdata;
            cnt <= cnt + 1'b1;
            if (last_beat) state <= S_DONE;
          end
        end
        S_WRITE: begin
          if (burst_resp) begin
            cnt <= cnt + 1'b1;
            if (last_beat) state <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs decode straight from the state.
  always_comb begin
    burst_read  = (state == S_READ);
    burst_write = (state == S_WRITE);
    pmem_resp   = (state == S_DONE);
    burst_wdata = '0;
    if (state == S_WRITE) burst_wdata = line_buf[cnt*s_beat +: s_beat];
  end

  assign burst_address = addr_q;
  assign pmem_rdata    = rdata_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter with a small DRAM model.
// Inputs change and outputs are sampled on the falling edge.
module tb_cacheline_adapter;

  logic         clk;
  logic         rst;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic         pmem_resp;
  logic [31:0]  burst_address;
  logic [63:0]  burst_rdata;
  logic [63:0]  burst_wdata;
  logic         burst_read;
  logic         burst_write;
  logic         burst_resp;

  cacheline_adapter dut (
    .clk(clk),
    .rst(rst),
    .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_resp(pmem_resp),
    .burst_address(burst_address),
    .burst_rdata(burst_rdata),
    .burst_wdata(burst_wdata),
    .burst_read(burst_read),
    .burst_write(burst_write),
    .burst_resp(burst_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [255:0] mem [logic [31:0]];

  int           lat;
  int           nresp;
  logic [255:0] wseen;
  logic [31:0]  addr_seen;
  bit           saw_bw;
  bit           busy_in_done;

  localparam logic [255:0] L1 = {{16{4'h4}}, {16{4'h3}},
                                 {16{4'h2}}, {16{4'h1}}};
  localparam logic [255:0] W1 = {{16{4'hD}}, {16{4'hC}},
                                 {16{4'hB}}, {16{4'hA}}};
  localparam logic [255:0] L3 = {64'h0123456789abcdef,
                                 64'hfedcba9876543210,
                                 64'h0f0f0f0f0f0f0f0f,
                                 64'hf0f0f0f0f0f0f0f0};
  localparam logic [255:0] W2 = {64'h0000000000000004,
                                 64'h0000000000000003,
                                 64'h0000000000000002,
                                 64'h0000000000000001};
  localparam logic [255:0] L4 = {64'h5555aaaa5555aaaa,
                                 64'h6666bbbb6666bbbb,
                                 64'h7777cccc7777cccc,
                                 64'h8888dddd8888dddd};

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One L2 transaction, started at the current falling edge.
  // lat counts the request cycle as cycle 1.
  task automatic xact(input bit wr, input bit both,
                      input logic [31:0] a,
                      input logic [255:0] wd,
                      input logic [15:0] pat);
    int b;
    int p;
    logic [255:0] tmp;
    b = 0;
    p = 0;
    lat = 1;
    nresp = 0;
    wseen = '0;
    addr_seen = '0;
    saw_bw = 0;
    busy_in_done = 1;
    pmem_address = a;
    pmem_wdata = wd;
    pmem_read = !wr || both;
    pmem_write = wr || both;
    burst_resp = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (burst_write) saw_bw = 1;
      if (pmem_resp) begin
        nresp = 1;
        busy_in_done = burst_read | burst_write;
        pmem_read = 0;
        pmem_write = 0;
        burst_resp = 0;
        break;
      end
      if (burst_read || burst_write) begin
        if (p == 0) addr_seen = burst_address;
        burst_resp = pat[p];
        p++;
        if (burst_resp) begin
          if (burst_read) begin
            tmp = mem.exists(burst_address) ? mem[burst_address] : '0;
            burst_rdata = tmp[64*b +: 64];
          end else begin
            wseen[64*b +: 64] = burst_wdata;
          end
          b++;
        end
      end else begin
        burst_resp = 0;
      end
    end
    if (nresp == 1 && wr && !both) mem[{a[31:5], 5'b0}] = wseen;
  endtask

  initial begin
    rst = 1;
    pmem_address = '0;
    pmem_wdata = '0;
    pmem_read = 0;
    pmem_write = 0;
    burst_rdata = '0;
    burst_resp = 0;
    mem[32'h0000_1220] = L1;
    mem[32'h0000_3040] = L3;
    mem[32'h0000_4000] = L4;

    @(negedge clk);
    chk("rst_rdata", pmem_rdata, '0);
    chk("rst_ctrl", {pmem_resp, burst_read, burst_write}, 3'b000);
    chk("rst_addr", burst_address, 32'h0);
    chk("rst_wdata", burst_wdata, 64'h0);
    rst = 0;
    @(negedge clk);

    // zero-stall read
    xact(0, 0, 32'h0000_1234, '0, 16'hFFFF);
    chk("rd_resp", nresp, 1);
    chk("rd_lat", lat, 6);
    chk("rd_addr", addr_seen, 32'h0000_1220);
    chk("rd_line", pmem_rdata, L1);
    chk("rd_done_idle", busy_in_done, 0);
    @(negedge clk);
    chk("rd_resp_1cyc", pmem_resp, 0);
    @(negedge clk);
    chk("rd_no_reaccept", {burst_read, burst_write}, 2'b00);

    // zero-stall write
    xact(1, 0, 32'h0000_2008, W1, 16'hFFFF);
    chk("wr_resp", nresp, 1);
    chk("wr_lat", lat, 6);
    chk("wr_addr", addr_seen, 32'h0000_2000);
    chk("wr_beats", wseen, W1);
    chk("wr_done_idle", busy_in_done, 0);
    chk("rdata_held", pmem_rdata, L1);
    @(negedge clk);
    chk("wr_resp_1cyc", pmem_resp, 0);

    // read with burst_resp 1,0,0,1,1,0,1
    xact(0, 0, 32'h0000_305f, '0, 16'b1011001);
    chk("stall_resp", nresp, 1);
    chk("stall_lat", lat, 9);
    chk("stall_line", pmem_rdata, L3);
    @(negedge clk);

    // asynchronous reset after two write beats
    pmem_address = 32'h0000_0500;
    pmem_wdata = W1;
    pmem_write = 1;
    @(negedge clk);
    chk("rw_wr_state", burst_write, 1);
    burst_resp = 1;
    @(negedge clk);
    @(negedge clk);
    chk("rw_beat2_data", burst_wdata, {16{4'hC}});
    #2 rst = 1;
    #1;
    chk("rw_ctrl", {pmem_resp, burst_read, burst_write}, 3'b000);
    chk("rw_addr", burst_address, 32'h0);
    chk("rw_wdata", burst_wdata, 64'h0);
    chk("rw_rdata", pmem_rdata, '0);
    pmem_write = 0;
    burst_resp = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rw_no_resp", {pmem_resp, burst_write}, 2'b00);
    xact(0, 0, 32'h0000_1234, '0, 16'hFFFF);
    chk("rw_rd_resp", nresp, 1);
    chk("rw_rd_lat", lat, 6);
    chk("rw_rd_line", pmem_rdata, L1);
    @(negedge clk);

    // back-to-back write then read of the same line
    xact(1, 0, 32'h0000_0100, W2, 16'hFFFF);
    chk("b2b_wr_beats", wseen, W2);
    xact(0, 0, 32'h0000_0100, '0, 16'hFFFF);
    chk("b2b_rd_resp", nresp, 1);
    chk("b2b_rd_lat", lat, 7);
    chk("b2b_rd_line", pmem_rdata, W2);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_no_reaccept", {pmem_resp, burst_read}, 2'b00);

    // stray burst_resp in IDLE
    burst_resp = 1;
    burst_rdata = 64'hdead_beef_dead_beef;
    repeat (3) @(negedge clk);
    chk("stray_ctrl", {pmem_resp, burst_read, burst_write}, 3'b000);
    chk("stray_addr", burst_address, 32'h0000_0100);
    chk("stray_rdata", pmem_rdata, W2);
    burst_resp = 0;
    @(negedge clk);

    // read and write together: read wins
    xact(0, 1, 32'h0000_4010, W1, 16'hFFFF);
    chk("both_resp", nresp, 1);
    chk("both_no_bw", saw_bw, 0);
    chk("both_line", pmem_rdata, L4);
    chk("both_addr", addr_seen, 32'h0000_4000);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
